add_approx_pipe: RTL and testbench
==================================

Name: add_approx_pipe

Overview:
Parametrised, pipelined approximate unsigned adder: the successor to the fixed 12-bit combinational approximate adders in the add12u family. The low APPROX_BITS bits use a run-time selectable approximation mode. The upper bits are an exact ripple sum, split into STAGES carry-pipelined segments. A valid/ready handshake with full stall support wraps the datapath. An exact shadow sum drives a per-result absolute-error output and running error statistics, used for on-chip WCE/MAE characterisation.

Parameters:
WIDTH, 12, operand width in bits (>=4).
APPROX_BITS, 7, number of approximated low bits K (0..WIDTH-1); K=0 makes every mode exact.
STAGES, 2, pipeline depth S and number of upper-part segments (1..4).
CNT_W, 32, width of the statistics transfer counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  adder can accept a beat
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_mode  in  2  0 exact, 1 LOA, 2 copy-A, 3 truncate; sampled with operands
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sum  out  WIDTH+1  approximate sum
out_err  out  WIDTH+1  |exact - approximate| for this result
stat_clr  in  1  synchronous clear of statistics
stat_max_err  out  WIDTH+1  largest out_err transferred since clear
stat_count  out  CNT_W  results transferred since clear, saturating

Behaviour:
- Reset: every stage valid bit clears immediately. out_valid=0, out_sum=0, out_err=0, stat_max_err=0, stat_count=0, in_ready=1 on the first cycle after release.
- Low part (bits K-1..0) and carry-in c0 into bit K, by mode:
  - mode 0: exact a+b, c0 = true carry out of the low part.
  - mode 1 (LOA): low = a|b, c0 = a[K-1]&b[K-1].
  - mode 2: low = a low bits, c0 = 0.
  - mode 3: low = 0, c0 = 0.
- Upper part (bits WIDTH-1..K): exact sum of a, b and c0, split into S segments of ceil((WIDTH-K)/S) bits. The last segment takes the remainder.
  - Segment i is added in stage i and uses the registered carry from stage i-1.
  - Operand bits of later segments travel through delay registers.
  - out_sum[WIDTH] is the final carry.
- Shadow exact sum: computed in stage 0 and delayed alongside. out_err is computed in the last stage and is never negative.
- Handshake and stalls:
  - A transfer occurs on a cycle where valid and ready are both high.
  - A stage advances when its successor is empty or is advancing. The last stage advances on out_ready.
  - in_ready = !valid[0] || advance[0], combinational from out_ready through the stall chain. No combinational path from in_valid to out_*.
  - Latency is S cycles from input transfer to out_valid when there is no stall. Throughput is 1 result per cycle.
  - Capacity is S results. Order is preserved. While out_valid=1 and out_ready=0, out_sum and out_err are held stable.
- Statistics: update only on an output transfer.
  - stat_max_err = max(stat_max_err, out_err).
  - stat_count increments and saturates at 2^CNT_W-1.
  - If stat_clr and a transfer occur in the same cycle, the clear wins and that transfer is not recorded.
- Reset mid-operation: all in-flight beats are discarded, with no partial output after reset release.
- Degenerate cases:
  - K=0: all modes give exact results and err=0.
  - S=1: one register stage, latency 1.

Test Plan:
- WIDTH=12, K=7, S=2, mode 0: a=0xFFF, b=0x001 -> out_sum=0x1000, out_err=0, out_valid exactly 2 cycles after the accept.
- Mode 1: a=0x07F, b=0x040 -> out_sum=0x0FF, out_err=0x040. Mode 2: a=0x07F, b=0x07F -> out_sum=0x07F, out_err=0x07F.
- Mode 3: a=0x0FF, b=0x0FF -> out_sum=0x100, out_err=0x0FE. Then stat_max_err=0x0FE and stat_count=4 after these four transfers.
- Backpressure: hold out_ready=0 and present 4 beats back-to-back -> in_ready falls after 2 accepts. Release out_ready -> all 4 results emerge in order with no loss or duplication, and outputs stay stable while stalled.
- Assert stat_clr on a cycle with an output transfer (err=0x040) -> next cycle stat_max_err=0, stat_count=0. The following transfer with err=0x7F -> stat_max_err=0x7F, stat_count=1.
- Assert rst_n low with 2 beats in flight -> out_valid=0 immediately. After release, no result appears until new input is accepted. Random sweep across all modes with K in {0,4,7} and S in {1,3} matches a reference model.

Source files
------------

// File: rtl/add_approx_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | add_approx_pipe_if                                                         |
// | Operand/result handshake and statistics bundle for add_approx_pipe.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface add_approx_pipe_if #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [WIDTH:0]   out_err;
  logic             stat_clr;
  logic [WIDTH:0]   stat_max_err;
  logic [CNT_W-1:0] stat_count;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready, stat_clr,
    input  in_ready, out_valid, out_sum, out_err, stat_max_err, stat_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready, stat_clr,
    output in_ready, out_valid, out_sum, out_err, stat_max_err, stat_count
  );
endinterface
`default_nettype wire

// File: rtl/add_approx_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | add_approx_pipe                                                            |
// | Pipelined approximate unsigned adder with exact shadow sum and error stats.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module add_approx_pipe #(
  parameter int WIDTH       = 12,
  parameter int APPROX_BITS = 7,
  parameter int STAGES      = 2,
  parameter int CNT_W       = 32
) (
  input wire               clk,
  input wire               rst_n,
  add_approx_pipe_if.slave io
);

  localparam int c_k   = APPROX_BITS;
  localparam int c_seg = (WIDTH - APPROX_BITS + STAGES - 1) / STAGES;

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_a     [STAGES];
  logic [WIDTH-1:0]  r_b     [STAGES];
  logic [WIDTH:0]    r_sum   [STAGES];
  logic              r_cy    [STAGES];
  logic [WIDTH:0]    r_exact [STAGES];
  logic [WIDTH:0]    r_err;
  logic [WIDTH:0]    r_max_err;
  logic [CNT_W-1:0]  r_count;

  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_vin;
  logic [WIDTH:0]    w_nsum [STAGES];
  logic              w_ncy  [STAGES];
  logic [WIDTH:0]    w_exin [STAGES];
  logic [WIDTH:0]    w_err;
  logic              w_xfer;

  // Segment bounds; trailing segments may be empty when WIDTH-K < STAGES.
  function automatic int f_lo(input int i);
    int lo;
    lo = c_k + i * c_seg;
    return (lo > WIDTH) ? WIDTH : lo;
  endfunction

  function automatic int f_hi(input int i);
    return (i == STAGES - 1) ? WIDTH : f_lo(i + 1);
  endfunction

  // Ripple-add bits [lo, hi) into s_in; returns {carry_out, sum}.
  function automatic logic [WIDTH+1:0] f_seg(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH:0]   s_in,
    input logic             c_in,
    input int               lo,
    input int               hi
  );
    logic [WIDTH:0] s;
    logic           c;
    s = s_in;
    c = c_in;
    for (int j = 0; j < WIDTH; j++) begin
      if (j >= lo && j < hi) begin
        s[j] = a[j] ^ b[j] ^ c;
        c    = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
      end
    end
    return {c, s};
  endfunction

  always_comb begin
    logic [WIDTH:0] w_low;
    logic           w_c0;
    w_low = '0;
    w_c0  = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (j < c_k) begin
        case (io.in_mode)
          2'd0: begin
            w_low[j] = io.in_a[j] ^ io.in_b[j] ^ w_c0;
            w_c0     = (io.in_a[j] & io.in_b[j]) | (w_c0 & (io.in_a[j] ^ io.in_b[j]));
          end
          2'd1: begin
            // Last iteration leaves c0 = a[K-1] & b[K-1].
            w_low[j] = io.in_a[j] | io.in_b[j];
            w_c0     = io.in_a[j] & io.in_b[j];
          end
          2'd2: begin
            w_low[j] = io.in_a[j];
            w_c0     = 1'b0;
          end
          default: begin
            w_low[j] = 1'b0;
            w_c0     = 1'b0;
          end
        endcase
      end
    end
    w_exin[0] = {1'b0, io.in_a} + {1'b0, io.in_b};
    {w_ncy[0], w_nsum[0]} = f_seg(io.in_a, io.in_b, w_low, w_c0, f_lo(0), f_hi(0));
    for (int i = 1; i < STAGES; i++) begin
      w_exin[i] = r_exact[i-1];
      {w_ncy[i], w_nsum[i]} = f_seg(r_a[i-1], r_b[i-1], r_sum[i-1], r_cy[i-1], f_lo(i), f_hi(i));
    end
    w_nsum[STAGES-1][WIDTH] = w_ncy[STAGES-1];
    w_err = (w_exin[STAGES-1] >= w_nsum[STAGES-1]) ? (w_exin[STAGES-1] - w_nsum[STAGES-1])
                                                   : (w_nsum[STAGES-1] - w_exin[STAGES-1]);
  end

  // Stall chain: a stage may load when empty or when its content moves on.
  always_comb begin
    logic w_adv;
    w_adv  = io.out_ready;
    w_load = '0;
    w_vin  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_load[i] = !r_valid[i] || w_adv;
      w_adv     = w_load[i];
    end
    w_vin[0] = io.in_valid;
    for (int i = 1; i < STAGES; i++) begin
      w_vin[i] = r_valid[i-1];
    end
  end

  assign w_xfer = r_valid[STAGES-1] & io.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_a[i]     <= '0;
        r_b[i]     <= '0;
        r_sum[i]   <= '0;
        r_cy[i]    <= 1'b0;
        r_exact[i] <= '0;
      end
      r_err     <= '0;
      r_max_err <= '0;
      r_count   <= '0;
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= io.in_valid;
        if (io.in_valid) begin
          r_a[0]     <= io.in_a;
          r_b[0]     <= io.in_b;
          r_sum[0]   <= w_nsum[0];
          r_cy[0]    <= w_ncy[0];
          r_exact[0] <= w_exin[0];
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= r_valid[i-1];
          if (r_valid[i-1]) begin
            r_a[i]     <= r_a[i-1];
            r_b[i]     <= r_b[i-1];
            r_sum[i]   <= w_nsum[i];
            r_cy[i]    <= w_ncy[i];
            r_exact[i] <= w_exin[i];
          end
        end
      end
      if (w_load[STAGES-1] && w_vin[STAGES-1]) begin
        r_err <= w_err;
      end
      if (io.stat_clr) begin
        r_max_err <= '0;
        r_count   <= '0;
      end else if (w_xfer) begin
        if (r_err > r_max_err) begin
          r_max_err <= r_err;
        end
        if (r_count != {CNT_W{1'b1}}) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign io.in_ready     = w_load[0];
  assign io.out_valid    = r_valid[STAGES-1];
  assign io.out_sum      = r_sum[STAGES-1];
  assign io.out_err      = r_err;
  assign io.stat_max_err = r_max_err;
  assign io.stat_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_add_approx_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_add_approx_pipe                                                         |
// | Directed and randomized checks of add_approx_pipe against a sum model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_add_approx_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_sw;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  add_approx_pipe_if #(.WIDTH(12), .CNT_W(32)) mif ();

  add_approx_pipe #(.WIDTH(12), .APPROX_BITS(7), .STAGES(2), .CNT_W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (mif)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Approximate sum straight from the mode definitions.
  function automatic int ref_approx(input int a, input int b, input int mode, input int k);
    int mask;
    int low;
    int c0;
    mask = (1 << k) - 1;
    low  = 0;
    c0   = 0;
    if (mode == 0) return a + b;
    if (mode == 1) begin
      low = (a | b) & mask;
      c0  = (k > 0) ? ((a >> (k - 1)) & (b >> (k - 1)) & 1) : 0;
    end else if (mode == 2) begin
      low = a & mask;
    end
    return (((a >> k) + (b >> k) + c0) << k) | low;
  endfunction

  function automatic int ref_err(input int a, input int b, input int mode, input int k);
    int d;
    d = (a + b) - ref_approx(a, b, mode, k);
    return (d < 0) ? -d : d;
  endfunction

  // Randomized sweep over K in {0,4,7} and S in {1,3}; 8-bit counter to reach saturation.
  for (genvar gi = 0; gi < 6; gi++) begin : g_sw
    localparam int c_k = (gi % 3 == 0) ? 0 : ((gi % 3 == 1) ? 4 : 7);
    localparam int c_s = (gi < 3) ? 1 : 3;

    add_approx_pipe_if #(.WIDTH(12), .CNT_W(8)) sif ();

    add_approx_pipe #(.WIDTH(12), .APPROX_BITS(c_k), .STAGES(c_s), .CNT_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_sw),
      .io    (sif)
    );

    logic done = 1'b0;
    int   q_sum[$];
    int   q_err[$];
    int   n_xfer  = 0;
    int   max_err = 0;
    int   es;
    int   ee;

    initial begin
      sif.in_valid  = 1'b0;
      sif.in_a      = '0;
      sif.in_b      = '0;
      sif.in_mode   = '0;
      sif.out_ready = 1'b0;
      sif.stat_clr  = 1'b0;
      @(posedge rst_sw);
      for (int n = 0; n < 600; n++) begin
        @(posedge clk);
        #1;
        sif.in_valid  = ($urandom_range(0, 3) != 0);
        sif.in_a      = 12'($urandom);
        sif.in_b      = 12'($urandom);
        sif.in_mode   = 2'($urandom_range(0, 3));
        sif.out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      for (int t = 0; t < 20 && q_sum.size() > 0; t++) @(posedge clk);
      @(negedge clk);
      check($sformatf("sw%0d_drain", gi), q_sum.size(), 0);
      check($sformatf("sw%0d_count", gi), sif.stat_count, (n_xfer > 255) ? 255 : n_xfer);
      check($sformatf("sw%0d_max_err", gi), sif.stat_max_err, max_err);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (rst_sw) begin
        if (sif.out_valid && sif.out_ready) begin
          if (q_sum.size() == 0) begin
            check($sformatf("sw%0d_spurious", gi), sif.out_valid, 0);
          end else begin
            es = q_sum.pop_front();
            ee = q_err.pop_front();
            check($sformatf("sw%0d_sum", gi), sif.out_sum, es);
            check($sformatf("sw%0d_err", gi), sif.out_err, ee);
            n_xfer++;
            if (ee > max_err) max_err = ee;
          end
        end
        if (sif.in_valid && sif.in_ready) begin
          q_sum.push_back(ref_approx(int'(sif.in_a), int'(sif.in_b), int'(sif.in_mode), c_k));
          q_err.push_back(ref_err(int'(sif.in_a), int'(sif.in_b), int'(sif.in_mode), c_k));
        end
      end
    end
  end

  // One beat through an empty pipe with out_ready high; returns latency and result.
  task automatic do_beat(input logic [11:0] a, input logic [11:0] b, input logic [1:0] mode,
                         input logic clr, output int lat, output logic [12:0] sum,
                         output logic [12:0] err);
    lat = 0;
    sum = '0;
    err = '0;
    @(posedge clk);
    #1;
    mif.in_valid = 1'b1;
    mif.in_a     = a;
    mif.in_b     = b;
    mif.in_mode  = mode;
    @(negedge clk);
    check("beat_in_ready", mif.in_ready, 1);
    @(posedge clk);
    #1;
    mif.in_valid = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (mif.out_valid) begin
        lat = t;
        sum = mif.out_sum;
        err = mif.out_err;
        break;
      end
    end
    if (clr) mif.stat_clr = 1'b1;
    @(posedge clk);
    #1;
    mif.stat_clr = 1'b0;
  endtask

  logic [11:0] bp_a [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
  logic [11:0] bp_b [4] = '{12'h321, 12'h654, 12'h987, 12'hCDE};
  logic [1:0]  bp_m [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

  initial begin
    int          lat;
    logic [12:0] s;
    logic [12:0] e;
    int          acc;
    int          got;
    int          seen;
    rst_n         = 1'b0;
    rst_sw        = 1'b0;
    mif.in_valid  = 1'b0;
    mif.in_a      = '0;
    mif.in_b      = '0;
    mif.in_mode   = '0;
    mif.out_ready = 1'b1;
    mif.stat_clr  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold_out_valid", mif.out_valid, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rst_sw = 1'b1;
    @(negedge clk);
    check("rst_in_ready", mif.in_ready, 1);
    check("rst_out_valid", mif.out_valid, 0);
    check("rst_out_sum", mif.out_sum, 0);
    check("rst_out_err", mif.out_err, 0);
    check("rst_max_err", mif.stat_max_err, 0);
    check("rst_count", mif.stat_count, 0);

    do_beat(12'hFFF, 12'h001, 2'd0, 1'b0, lat, s, e);
    check("m0_latency", lat, 2);
    check("m0_sum", s, 13'h1000);
    check("m0_err", e, 0);
    do_beat(12'h07F, 12'h040, 2'd1, 1'b0, lat, s, e);
    check("m1_sum", s, 13'h0FF);
    check("m1_err", e, 13'h040);
    do_beat(12'h07F, 12'h07F, 2'd2, 1'b0, lat, s, e);
    check("m2_sum", s, 13'h07F);
    check("m2_err", e, 13'h07F);
    do_beat(12'h0FF, 12'h0FF, 2'd3, 1'b0, lat, s, e);
    check("m3_sum", s, 13'h100);
    check("m3_err", e, 13'h0FE);
    @(negedge clk);
    check("stat4_max_err", mif.stat_max_err, 13'h0FE);
    check("stat4_count", mif.stat_count, 4);

    // Backpressure: stalled sink, four beats offered back to back.
    mif.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      mif.in_valid = (acc < 4);
      if (acc < 4) begin
        mif.in_a    = bp_a[acc];
        mif.in_b    = bp_b[acc];
        mif.in_mode = bp_m[acc];
      end
      @(negedge clk);
      if (mif.in_valid && mif.in_ready) acc++;
      if (mif.out_valid) begin
        check("bp_hold_sum", mif.out_sum, ref_approx(int'(bp_a[0]), int'(bp_b[0]), int'(bp_m[0]), 7));
        check("bp_hold_err", mif.out_err, ref_err(int'(bp_a[0]), int'(bp_b[0]), int'(bp_m[0]), 7));
      end
    end
    check("bp_accepts", acc, 2);
    check("bp_in_ready_low", mif.in_ready, 0);
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(posedge clk);
      #1;
      mif.out_ready = 1'b1;
      mif.in_valid  = (acc < 4);
      if (acc < 4) begin
        mif.in_a    = bp_a[acc];
        mif.in_b    = bp_b[acc];
        mif.in_mode = bp_m[acc];
      end
      @(negedge clk);
      if (mif.out_valid && mif.out_ready) begin
        check("bp_order_sum", mif.out_sum, ref_approx(int'(bp_a[got]), int'(bp_b[got]), int'(bp_m[got]), 7));
        check("bp_order_err", mif.out_err, ref_err(int'(bp_a[got]), int'(bp_b[got]), int'(bp_m[got]), 7));
        got++;
      end
      if (mif.in_valid && mif.in_ready) acc++;
    end
    check("bp_results", got, 4);
    @(posedge clk);
    #1;
    mif.in_valid = 1'b0;
    @(negedge clk);
    check("bp_no_dup", mif.out_valid, 0);

    // Clear coinciding with a transfer: the clear wins.
    do_beat(12'h07F, 12'h040, 2'd1, 1'b1, lat, s, e);
    check("clr_beat_err", e, 13'h040);
    @(negedge clk);
    check("clr_max_err", mif.stat_max_err, 0);
    check("clr_count", mif.stat_count, 0);
    do_beat(12'h07F, 12'h07F, 2'd2, 1'b0, lat, s, e);
    @(negedge clk);
    check("post_clr_max_err", mif.stat_max_err, 13'h07F);
    check("post_clr_count", mif.stat_count, 1);

    // Reset with two beats in flight.
    @(posedge clk);
    #1;
    mif.out_ready = 1'b0;
    mif.in_valid  = 1'b1;
    mif.in_a      = 12'h111;
    mif.in_b      = 12'h222;
    mif.in_mode   = 2'd0;
    @(posedge clk);
    #1;
    mif.in_a = 12'h333;
    mif.in_b = 12'h044;
    @(posedge clk);
    #1;
    mif.in_valid = 1'b0;
    @(negedge clk);
    check("rm_pre_valid", mif.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rm_out_valid", mif.out_valid, 0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    mif.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mif.out_valid) seen++;
    end
    check("rm_no_output", seen, 0);
    check("rm_count", mif.stat_count, 0);
    do_beat(12'h07F, 12'h040, 2'd1, 1'b0, lat, s, e);
    check("rm_new_latency", lat, 2);
    check("rm_new_sum", s, 13'h0FF);

    for (int t = 0; t < 3000; t++) begin
      if (g_sw[0].done && g_sw[1].done && g_sw[2].done &&
          g_sw[3].done && g_sw[4].done && g_sw[5].done) break;
      @(posedge clk);
    end
    check("sweep_done", {g_sw[0].done, g_sw[1].done, g_sw[2].done,
                         g_sw[3].done, g_sw[4].done, g_sw[5].done}, 6'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
